// File: rtl/ahblite_led_ctrl_pkg.sv
// Shared definitions for the AHB-Lite LED controller: register word offsets
// and the AHB transfer encodings the slave decodes.
package ahblite_led_ctrl_pkg;

    localparam logic [2:0] LED_DATA   = 3'd0;
    localparam logic [2:0] LED_SET    = 3'd1;
    localparam logic [2:0] LED_CLR    = 3'd2;
    localparam logic [2:0] LED_MODE   = 3'd3;
    localparam logic [2:0] LED_PERIOD = 3'd4;
    localparam logic [2:0] LED_STATUS = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahblite_led_ctrl_prescaler.sv
// Blink prescaler: free-running counter that toggles the blink phase each
// time it reaches the programmed period; period 0 holds the phase lit.
module led_blink_prescaler #(
    parameter int unsigned PRESC_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRESC_W-1:0] period,
    input  logic               reload,
    output logic               phase
);

    localparam logic [PRESC_W-1:0] CNT_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] cnt;

    // Reload on a PERIOD write outranks the wrap so the new period starts clean.
    always_ff @(posedge clk) begin
        if (reset || reload || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ahblite_led_ctrl.sv
// AHB-Lite slave for a bank of board LEDs: data, atomic set/clear,
// per-channel blink mode and a programmable blink period.
module ahblite_led_ctrl
    import ahblite_led_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned PRESC_W    = 24,
    parameter int unsigned RST_PERIOD = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [NUM_LEDS-1:0] LED
);

    logic                accept;
    logic                dp_valid;
    logic                dp_write;
    logic                dp_size_ok;
    logic [2:0]          dp_addr;
    logic                wr_en;
    logic                period_wr;
    logic [NUM_LEDS-1:0] wbits;
    logic [NUM_LEDS-1:0] data_r;
    logic [NUM_LEDS-1:0] mode_r;
    logic [NUM_LEDS-1:0] led_r;
    logic [PRESC_W-1:0]  period_r;
    logic                phase;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign accept = HSEL && HREADY &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_size_ok <= 1'b0;
            dp_addr    <= '0;
        end else if (HREADY) begin
            dp_valid   <= accept;
            dp_write   <= HWRITE;
            dp_size_ok <= (HSIZE == HSIZE_WORD);
            dp_addr    <= HADDR[4:2];
        end
    end

    assign wr_en     = dp_valid && dp_write && dp_size_ok;
    assign period_wr = wr_en && (dp_addr == LED_PERIOD);
    assign wbits     = HWDATA[NUM_LEDS-1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_r   <= '0;
            mode_r   <= '0;
            period_r <= PRESC_W'(RST_PERIOD);
        end else if (wr_en) begin
            case (dp_addr)
                LED_DATA:   data_r   <= wbits;
                LED_SET:    data_r   <= data_r | wbits;
                LED_CLR:    data_r   <= data_r & ~wbits;
                LED_MODE:   mode_r   <= wbits;
                LED_PERIOD: period_r <= HWDATA[PRESC_W-1:0];
                default:    ;
            endcase
        end
    end

    led_blink_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk    (HCLK),
        .reset  (HRESET),
        .period (period_r),
        .reload (period_wr),
        .phase  (phase)
    );

    // Read mux uses live register state, so a read right after a write sees the new value.
    always_comb begin
        rdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                LED_DATA:   rdata[NUM_LEDS-1:0] = data_r;
                LED_MODE:   rdata[NUM_LEDS-1:0] = mode_r;
                LED_PERIOD: rdata[PRESC_W-1:0]  = period_r;
                LED_STATUS: rdata[0]            = phase;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            led_r <= '0;
        end else begin
            led_r <= data_r & (~mode_r | {NUM_LEDS{phase}});
        end
    end

    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HWDATA};

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign LED       = led_r;

endmodule

// File: tb/tb_ahblite_led_ctrl.sv
// Directed self-checking bench for ahblite_led_ctrl (NUM_LEDS=8, PRESC_W=24).
module tb_ahblite_led_ctrl;

    logic        HCLK;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [7:0]  LED;

    int n_checks = 0;
    int n_fail   = 0;

    ahblite_led_ctrl #(
        .NUM_LEDS   (8),
        .PRESC_W    (24),
        .RST_PERIOD (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .LED       (LED)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] size);
        HSEL   = 1'b1;
        HADDR  = addr;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HSIZE  = size;
        @(posedge HCLK); #1;
        go_idle();
        HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL   = 1'b1;
        HADDR  = addr;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        @(posedge HCLK); #1;
        go_idle();
        data = HRDATA;
        check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("hresp", {31'b0, HRESP}, 32'd0);
        @(posedge HCLK); #1;
    endtask

    logic [31:0] rd;
    logic        ph_exp;
    logic        led0_exp;

    initial begin
        HRESET = 1'b1;
        HREADY = 1'b1;
        HADDR  = '0;
        HWDATA = '0;
        go_idle();
        repeat (3) @(posedge HCLK);
        #1;
        check("reset_led", {24'b0, LED}, 32'h0);
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_hreadyout", {31'b0, HREADYOUT}, 32'd1);
        check("reset_hresp", {31'b0, HRESP}, 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // 1: DATA write reaches LED one cycle after the data phase
        bus_write(32'h00, 32'h0000_00A5, 3'b010);
        check("led_before_update", {24'b0, LED}, 32'h0);
        check("write_hrdata_zero", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        check("led_a5", {24'b0, LED}, 32'hA5);
        bus_read(32'h00, rd);
        check("read_data_a5", rd, 32'hA5);

        // 2: atomic set / clear
        bus_write(32'h04, 32'h0F, 3'b010);
        bus_read(32'h00, rd);
        check("set_data_af", rd, 32'hAF);
        bus_write(32'h08, 32'h81, 3'b010);
        bus_read(32'h00, rd);
        check("clr_data_2e", rd, 32'h2E);
        bus_read(32'h04, rd);
        check("read_set_zero", rd, 32'h0);
        bus_read(32'h08, rd);
        check("read_clr_zero", rd, 32'h0);
        check("led_2e", {24'b0, LED}, 32'h2E);

        // 3: blink with PERIOD=3; phase lasts 4 cycles, STATUS read every cycle
        bus_write(32'h00, 32'h03, 3'b010);
        bus_write(32'h0C, 32'h01, 3'b010);
        bus_write(32'h10, 32'h03, 3'b010);
        check("blink_start_led", {24'b0, LED}, 32'h03);
        HSEL   = 1'b1;
        HADDR  = 32'h14;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge HCLK); #1;
            ph_exp   = ((k / 4) % 2) == 0;
            led0_exp = (((k - 1) / 4) % 2) == 0;
            check($sformatf("status_k%0d", k), HRDATA, {31'b0, ph_exp});
            check($sformatf("blink_led_k%0d", k), {24'b0, LED}, {30'b0, 1'b1, led0_exp});
        end
        go_idle();
        @(posedge HCLK); #1;
        bus_read(32'h10, rd);
        check("read_period_3", rd, 32'h3);

        // 4: reset during a write data phase drops the write
        HSEL   = 1'b1;
        HADDR  = 32'h00;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        @(posedge HCLK); #1;
        go_idle();
        HWDATA = 32'hFF;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        check("midreset_led", {24'b0, LED}, 32'h0);
        check("midreset_hrdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        check("midreset_led_hold", {24'b0, LED}, 32'h0);
        bus_read(32'h00, rd);
        check("midreset_data", rd, 32'h0);
        bus_read(32'h0C, rd);
        check("midreset_mode", rd, 32'h0);
        bus_read(32'h10, rd);
        check("midreset_period", rd, 32'h0);
        bus_read(32'h14, rd);
        check("midreset_status", rd, 32'h1);

        // 5: upper bits, unmapped offsets and sub-word writes are ignored
        bus_write(32'h00, 32'hFFFF_FF5A, 3'b010);
        bus_read(32'h00, rd);
        check("data_upper_bits", rd, 32'h5A);
        bus_write(32'h18, 32'hFFFF_FFFF, 3'b010);
        bus_write(32'h00, 32'h0000_0000, 3'b000);
        bus_read(32'h00, rd);
        check("byte_write_ignored", rd, 32'h5A);
        bus_read(32'h18, rd);
        check("read_0x18", rd, 32'h0);
        bus_read(32'h1C, rd);
        check("read_0x1c", rd, 32'h0);
        check("led_5a", {24'b0, LED}, 32'h5A);

        // 6: write MODE then read MODE in the very next data phase
        @(posedge HCLK); #1;
        HSEL   = 1'b1;
        HADDR  = 32'h0C;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        @(posedge HCLK); #1;
        HWDATA = 32'hFF;
        HWRITE = 1'b0;
        @(posedge HCLK); #1;
        go_idle();
        check("b2b_read_mode", HRDATA, 32'hFF);
        @(posedge HCLK); #1;
        check("idle_hrdata_zero", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        bus_read(32'h0C, rd);
        check("read_mode_ff", rd, 32'hFF);
        check("led_mode_ff_steady", {24'b0, LED}, 32'h5A);

        // Transfer without HSEL must not be accepted
        HSEL   = 1'b0;
        HADDR  = 32'h00;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        @(posedge HCLK); #1;
        go_idle();
        HWDATA = 32'h00;
        @(posedge HCLK); #1;
        bus_read(32'h00, rd);
        check("unselected_write", rd, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
